// File: rtl/clock_divider_multiphase.sv
// Multi-channel programmable clock divider: one master period counter, per-channel phase
// offsets, shared duty, glitch-free enables and boundary-aligned shadow configuration loads.
module clock_divider_multiphase #(
   parameter int DIVISOR_BITS = 8,
   parameter int NUM_CH       = 4
) (
   input  logic                           clk_in,
   input  logic                           rst,
   input  logic [DIVISOR_BITS-1:0]        divisor,
   input  logic [DIVISOR_BITS-1:0]        duty,
   input  logic [NUM_CH*DIVISOR_BITS-1:0] phase,
   input  logic                           load,
   input  logic [NUM_CH-1:0]              ch_enable,
   output logic [NUM_CH-1:0]              clk_out,
   output logic                           sync,
   output logic                           load_pending,
   output logic                           load_ack,
   output logic                           cfg_err
);

   localparam int W = DIVISOR_BITS;
   typedef logic [W-1:0]        val_t;
   typedef logic [NUM_CH*W-1:0] ph_t;

   function automatic val_t legal_d(input val_t div);
      return (div < val_t'(2)) ? val_t'(2) : div;
   endfunction

   function automatic val_t legal_h(input val_t dt, input val_t d);
      return (dt > d) ? d : dt;
   endfunction

   function automatic ph_t legal_p(input ph_t ph, input val_t d);
      ph_t res;
      res = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         res[k*W +: W] = (ph[k*W +: W] < d) ? ph[k*W +: W] : val_t'(0);
      end
      return res;
   endfunction

   function automatic logic cfg_bad(input val_t div, input val_t dt, input ph_t ph);
      val_t d;
      logic bad;
      d   = legal_d(div);
      bad = (div < val_t'(2)) | (dt > d);
      for (int k = 0; k < NUM_CH; k++) begin
         bad = bad | (ph[k*W +: W] >= d);
      end
      return bad;
   endfunction

   logic [W-1:0]        cnt_r;
   logic [W-1:0]        d_r;
   logic [W-1:0]        h_r;
   ph_t                 p_r;
   logic                err_r;
   logic                pend_r;
   logic [W-1:0]        sh_div_r;
   logic [W-1:0]        sh_duty_r;
   ph_t                 sh_ph_r;
   logic [NUM_CH-1:0]   en_r;

   logic [W-1:0]        src_div_s;
   logic [W-1:0]        src_duty_s;
   ph_t                 src_ph_s;
   logic                boundary_s;
   logic [NUM_CH-1:0]   hi_s;
   logic [NUM_CH-1:0]   wrap_s;

   assign load_pending = pend_r;

   // A load in the boundary cycle itself bypasses the shadow and activates directly.
   always_comb begin
      src_div_s  = sh_div_r;
      src_duty_s = sh_duty_r;
      src_ph_s   = sh_ph_r;
      if (load) begin
         src_div_s  = divisor;
         src_duty_s = duty;
         src_ph_s   = phase;
      end else begin
         src_div_s  = sh_div_r;
         src_duty_s = sh_duty_r;
         src_ph_s   = sh_ph_r;
      end
   end

   // Per-channel phase-shifted count, evaluated one bit wider so cnt + D cannot wrap.
   always_comb begin
      logic [W:0] cc;
      boundary_s = ({1'b0, cnt_r} >= ({1'b0, d_r} - (W+1)'(1)));
      hi_s       = '0;
      wrap_s     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cnt_r >= p_r[k*W +: W]) begin
            cc = {1'b0, cnt_r} - {1'b0, p_r[k*W +: W]};
         end else begin
            cc = {1'b0, cnt_r} + {1'b0, d_r} - {1'b0, p_r[k*W +: W]};
         end
         hi_s[k]   = (cc < {1'b0, h_r});
         wrap_s[k] = (cc == ({1'b0, d_r} - (W+1)'(1)));
      end
   end

   // Master counter, configuration activation, channel enables and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_r     <= '0;
         d_r       <= legal_d(divisor);
         h_r       <= legal_h(duty, legal_d(divisor));
         p_r       <= legal_p(phase, legal_d(divisor));
         err_r     <= cfg_bad(divisor, duty, phase);
         pend_r    <= 1'b0;
         sh_div_r  <= '0;
         sh_duty_r <= '0;
         sh_ph_r   <= '0;
         en_r      <= '0;
         clk_out   <= '0;
         sync      <= 1'b0;
         load_ack  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            clk_out[k] <= en_r[k] & hi_s[k];
            if (wrap_s[k]) begin
               en_r[k] <= ch_enable[k];
            end
         end
         sync <= (cnt_r == val_t'(0));
         if (boundary_s) begin
            cnt_r <= '0;
            if (pend_r | load) begin
               d_r      <= legal_d(src_div_s);
               h_r      <= legal_h(src_duty_s, legal_d(src_div_s));
               p_r      <= legal_p(src_ph_s, legal_d(src_div_s));
               err_r    <= cfg_bad(src_div_s, src_duty_s, src_ph_s);
               cfg_err  <= cfg_bad(src_div_s, src_duty_s, src_ph_s);
               pend_r   <= 1'b0;
               load_ack <= 1'b1;
            end else begin
               cfg_err  <= err_r;
               load_ack <= 1'b0;
            end
         end else begin
            cnt_r    <= cnt_r + val_t'(1);
            cfg_err  <= err_r;
            load_ack <= 1'b0;
            if (load) begin
               sh_div_r  <= divisor;
               sh_duty_r <= duty;
               sh_ph_r   <= phase;
               pend_r    <= 1'b1;
            end
         end
      end
   end

endmodule
